// File: rtl/ptw_tlb_responder.sv
// Sv39-style page-table walker serving one TLB miss at a time over a single-outstanding memory port.
// Optional build macro PTW_AD_CHECK_EN: leaf PTEs with A clear (or D clear on a store) fault.
module ptw_tlb_responder #(
  parameter int PPN_W = 20,
  parameter int VPN_W = 27
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               tlb_req_valid_i,
  output logic               tlb_req_ready_o,
  input  logic [VPN_W-1:0]   tlb_req_vpn_i,
  input  logic [1:0]         tlb_req_prv_i,
  input  logic               tlb_req_store_i,
  input  logic               tlb_req_fetch_i,
  output logic               ptw_resp_valid_o,
  output logic               ptw_resp_error_o,
  output logic [63:0]        ptw_resp_pte_o,
  output logic [1:0]         ptw_resp_level_o,
  output logic               ptw_invalidate_o,
  input  logic [PPN_W-1:0]   satp_ppn_i,
  input  logic               sfence_i,
  output logic               mem_req_valid_o,
  input  logic               mem_req_ready_i,
  output logic [PPN_W+11:0]  mem_req_addr_o,
  input  logic               mem_resp_valid_i,
  input  logic [63:0]        mem_resp_data_i
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t             state_q, state_d;
  logic [VPN_W-1:0]   vpn_q, vpn_d;
  logic               store_q, store_d;
  logic [1:0]         prv_q, prv_d;
  logic               fetch_q, fetch_d;
  logic [PPN_W-1:0]   base_q, base_d;
  logic [1:0]         lvl_q, lvl_d;
  logic               restart_q, restart_d;
  logic [63:0]        resp_pte_q, resp_pte_d;
  logic               resp_err_q, resp_err_d;
  logic [1:0]         resp_lvl_q, resp_lvl_d;
  logic               invalidate_q;

  logic [8:0]         vpn_idx;
  logic [PPN_W-1:0]   pte_ppn;
  logic               pte_v, pte_r, pte_w, pte_x;
  logic               misaligned, ad_fault, unused_ctx;

  assign pte_ppn = mem_resp_data_i[10 +: PPN_W];
  assign pte_v   = mem_resp_data_i[0];
  assign pte_r   = mem_resp_data_i[1];
  assign pte_w   = mem_resp_data_i[2];
  assign pte_x   = mem_resp_data_i[3];

`ifdef PTW_AD_CHECK_EN
  assign ad_fault   = !mem_resp_data_i[6] | (store_q & !mem_resp_data_i[7]);
  assign unused_ctx = ^{prv_q, fetch_q};
`else
  assign ad_fault   = 1'b0;
  assign unused_ctx = ^{prv_q, fetch_q, store_q};
`endif

  always_comb begin
    vpn_idx    = vpn_q[8:0];
    misaligned = 1'b0;
    case (lvl_q)
      2'd0: begin
        vpn_idx    = vpn_q[VPN_W-1 -: 9];
        misaligned = |pte_ppn[17:0];
      end
      2'd1: begin
        vpn_idx    = vpn_q[VPN_W-10 -: 9];
        misaligned = |pte_ppn[8:0];
      end
      default: ;
    endcase
  end

  assign tlb_req_ready_o  = (state_q == S_IDLE);
  assign mem_req_valid_o  = (state_q == S_REQ);
  assign mem_req_addr_o   = mem_req_valid_o ? {base_q, vpn_idx, 3'b000} : '0;
  assign ptw_resp_valid_o = (state_q == S_RESP);
  assign ptw_resp_error_o = resp_err_q;
  assign ptw_resp_pte_o   = resp_pte_q;
  assign ptw_resp_level_o = resp_lvl_q;
  assign ptw_invalidate_o = invalidate_q;

  // A pending sfence (or one arriving with the data) discards the PTE and restarts from the root.
  always_comb begin
    state_d    = state_q;
    vpn_d      = vpn_q;
    store_d    = store_q;
    prv_d      = prv_q;
    fetch_d    = fetch_q;
    base_d     = base_q;
    lvl_d      = lvl_q;
    restart_d  = restart_q;
    resp_pte_d = resp_pte_q;
    resp_err_d = resp_err_q;
    resp_lvl_d = resp_lvl_q;

    if (sfence_i && (state_q == S_REQ || state_q == S_WAIT)) restart_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (tlb_req_valid_i) begin
          vpn_d     = tlb_req_vpn_i;
          store_d   = tlb_req_store_i;
          prv_d     = tlb_req_prv_i;
          fetch_d   = tlb_req_fetch_i;
          base_d    = satp_ppn_i;
          lvl_d     = 2'd0;
          restart_d = 1'b0;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_req_ready_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_resp_valid_i) begin
          if (restart_q || sfence_i) begin
            base_d    = satp_ppn_i;
            lvl_d     = 2'd0;
            restart_d = 1'b0;
            state_d   = S_REQ;
          end else if (!pte_v || (!pte_r && pte_w)) begin
            resp_err_d = 1'b1;
            resp_pte_d = '0;
            resp_lvl_d = lvl_q;
            state_d    = S_RESP;
          end else if (pte_r || pte_x) begin
            resp_err_d = misaligned | ad_fault;
            resp_pte_d = (misaligned | ad_fault) ? 64'd0 : mem_resp_data_i;
            resp_lvl_d = lvl_q;
            state_d    = S_RESP;
          end else if (lvl_q == 2'd2) begin
            resp_err_d = 1'b1;
            resp_pte_d = '0;
            resp_lvl_d = lvl_q;
            state_d    = S_RESP;
          end else begin
            base_d  = pte_ppn;
            lvl_d   = lvl_q + 2'd1;
            state_d = S_REQ;
          end
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      vpn_q        <= '0;
      store_q      <= 1'b0;
      prv_q        <= '0;
      fetch_q      <= 1'b0;
      base_q       <= '0;
      lvl_q        <= '0;
      restart_q    <= 1'b0;
      resp_pte_q   <= '0;
      resp_err_q   <= 1'b0;
      resp_lvl_q   <= '0;
      invalidate_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      vpn_q        <= vpn_d;
      store_q      <= store_d;
      prv_q        <= prv_d;
      fetch_q      <= fetch_d;
      base_q       <= base_d;
      lvl_q        <= lvl_d;
      restart_q    <= restart_d;
      resp_pte_q   <= resp_pte_d;
      resp_err_q   <= resp_err_d;
      resp_lvl_q   <= resp_lvl_d;
      invalidate_q <= sfence_i;
    end
  end

endmodule

// File: tb/tb_ptw_tlb_responder.sv
// Directed bench for ptw_tlb_responder: vector table of walks plus back-pressure, sfence and reset sequences.
module tb_ptw_tlb_responder;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         tlb_req_valid_i = 1'b0;
  logic         tlb_req_ready_o;
  logic [26:0]  tlb_req_vpn_i = '0;
  logic [1:0]   tlb_req_prv_i = '0;
  logic         tlb_req_store_i = 1'b0;
  logic         tlb_req_fetch_i = 1'b0;
  logic         ptw_resp_valid_o;
  logic         ptw_resp_error_o;
  logic [63:0]  ptw_resp_pte_o;
  logic [1:0]   ptw_resp_level_o;
  logic         ptw_invalidate_o;
  logic [19:0]  satp_ppn_i = '0;
  logic         sfence_i = 1'b0;
  logic         mem_req_valid_o;
  logic         mem_req_ready_i = 1'b0;
  logic [31:0]  mem_req_addr_o;
  logic         mem_resp_valid_i = 1'b0;
  logic [63:0]  mem_resp_data_i = '0;

  ptw_tlb_responder dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .tlb_req_valid_i(tlb_req_valid_i), .tlb_req_ready_o(tlb_req_ready_o),
    .tlb_req_vpn_i(tlb_req_vpn_i), .tlb_req_prv_i(tlb_req_prv_i),
    .tlb_req_store_i(tlb_req_store_i), .tlb_req_fetch_i(tlb_req_fetch_i),
    .ptw_resp_valid_o(ptw_resp_valid_o), .ptw_resp_error_o(ptw_resp_error_o),
    .ptw_resp_pte_o(ptw_resp_pte_o), .ptw_resp_level_o(ptw_resp_level_o),
    .ptw_invalidate_o(ptw_invalidate_o), .satp_ppn_i(satp_ppn_i), .sfence_i(sfence_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o(mem_req_addr_o), .mem_resp_valid_i(mem_resp_valid_i),
    .mem_resp_data_i(mem_resp_data_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Memory model state: the test writes the table and knobs, the model owns the counters.
  logic [63:0] mem_tbl [logic [31:0]];
  int          resp_delay   = 0;
  int          stall_budget = 0;
  int          stalls_given = 0;
  int          read_total   = 0;
  int          stab_viol    = 0;
  logic        pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] addr_log [$];

  function automatic logic [63:0] mem_lookup(input logic [31:0] a);
    if (mem_tbl.exists(a)) return mem_tbl[a];
    return 64'd0;
  endfunction

  always @(negedge clk_i) begin
    mem_resp_valid_i = 1'b0;
    mem_resp_data_i  = '0;
    if (pend) begin
      if (pend_cnt == 0) begin
        mem_resp_valid_i = 1'b1;
        mem_resp_data_i  = mem_lookup(pend_addr);
        pend = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
    if (prev_stall && (!mem_req_valid_o || mem_req_addr_o != prev_addr)) stab_viol++;
    if (mem_req_valid_o && stalls_given < stall_budget) begin
      mem_req_ready_i = 1'b0;
      stalls_given++;
    end else begin
      mem_req_ready_i = 1'b1;
    end
    prev_stall = mem_req_valid_o && !mem_req_ready_i;
    prev_addr  = mem_req_addr_o;
    if (mem_req_valid_o && mem_req_ready_i) begin
      pend      = 1'b1;
      pend_cnt  = resp_delay;
      pend_addr = mem_req_addr_o;
      read_total++;
      addr_log.push_back(mem_req_addr_o);
    end
  end

  typedef struct {
    string       name;
    logic [19:0] satp;
    logic [26:0] vpn;
    logic        store;
    int          n;
    logic [31:0] a0, a1, a2;
    logic [63:0] d0, d1, d2;
    logic        exp_err;
    logic [1:0]  exp_lvl;
    logic [63:0] exp_pte;
    int          exp_reads;
    int          exp_lat;
  } vec_t;

  vec_t vecs [10];

  function automatic logic [63:0] pte_of(input logic [19:0] ppn, input logic [7:0] flags);
    return {34'd0, ppn, 2'b00, flags};
  endfunction

  function automatic vec_t mk(input string name, input logic [19:0] satp, input logic [26:0] vpn,
                              input logic store, input int n,
                              input logic [31:0] a0, input logic [63:0] d0,
                              input logic [31:0] a1, input logic [63:0] d1,
                              input logic [31:0] a2, input logic [63:0] d2,
                              input logic exp_err, input logic [1:0] exp_lvl,
                              input logic [63:0] exp_pte, input int exp_reads, input int exp_lat);
    vec_t v;
    v.name = name; v.satp = satp; v.vpn = vpn; v.store = store; v.n = n;
    v.a0 = a0; v.a1 = a1; v.a2 = a2; v.d0 = d0; v.d1 = d1; v.d2 = d2;
    v.exp_err = exp_err; v.exp_lvl = exp_lvl; v.exp_pte = exp_pte;
    v.exp_reads = exp_reads; v.exp_lat = exp_lat;
    return v;
  endfunction

  task automatic load_vec(input vec_t v);
    mem_tbl.delete();
    if (v.n > 0) mem_tbl[v.a0] = v.d0;
    if (v.n > 1) mem_tbl[v.a1] = v.d1;
    if (v.n > 2) mem_tbl[v.a2] = v.d2;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Issues one request at a negedge and follows it to the response; t counts cycles after acceptance.
  task automatic applyStimulus(input logic [19:0] satp, input logic [26:0] vpn, input logic store,
                               input int sfence_at, output logic found, output int lat,
                               output logic err, output logic [1:0] lvl, output logic [63:0] pte,
                               output int inval_t, output int inval_n, output logic pulse_ok);
    found = 1'b0; lat = -1; err = 1'b0; lvl = '0; pte = '0;
    inval_t = -1; inval_n = 0; pulse_ok = 1'b0;
    @(negedge clk_i);
    satp_ppn_i      = satp;
    tlb_req_vpn_i   = vpn;
    tlb_req_store_i = store;
    tlb_req_valid_i = 1'b1;
    sfence_i        = (sfence_at == 0);
    for (int t = 1; t <= 200 && !found; t++) begin
      @(negedge clk_i);
      tlb_req_valid_i = 1'b0;
      sfence_i        = (t == sfence_at);
      if (ptw_invalidate_o) begin
        inval_n++;
        if (inval_t < 0) inval_t = t;
      end
      if (ptw_resp_valid_o) begin
        found = 1'b1;
        lat   = t;
        err   = ptw_resp_error_o;
        lvl   = ptw_resp_level_o;
        pte   = ptw_resp_pte_o;
      end
    end
    sfence_i = 1'b0;
    if (found) begin
      @(negedge clk_i);
      if (ptw_invalidate_o) inval_n++;
      pulse_ok = !ptw_resp_valid_o && tlb_req_ready_o;
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic        found, err, pulse_ok;
    logic [1:0]  lvl;
    logic [63:0] pte;
    int          lat, inval_t, inval_n, r0, l0, s0, v0, seen_resp, seen_req;

    vecs[0] = mk("walk4k", 20'h80, 27'h401, 1'b0, 3,
                 32'h80000, pte_of(20'h81, 8'h01), 32'h81010, pte_of(20'h82, 8'h01),
                 32'h82008, pte_of(20'h12345, 8'hCF), 1'b0, 2'd2, 64'h48D14CF, 3, 7);
    vecs[1] = mk("giga_ok", 20'h80, 27'h401, 1'b0, 1,
                 32'h80000, pte_of(20'h40000, 8'hCF), 32'h0, 64'h0, 32'h0, 64'h0,
                 1'b0, 2'd0, 64'h100000CF, 1, 3);
    vecs[2] = mk("giga_misaligned", 20'h80, 27'h401, 1'b0, 1,
                 32'h80000, pte_of(20'h40001, 8'hCF), 32'h0, 64'h0, 32'h0, 64'h0,
                 1'b1, 2'd0, 64'h0, 1, 3);
    vecs[3] = mk("root_zero", 20'h80, 27'h401, 1'b0, 1,
                 32'h80000, 64'h0, 32'h0, 64'h0, 32'h0, 64'h0, 1'b1, 2'd0, 64'h0, 1, 3);
    vecs[4] = mk("ptr_at_lvl2", 20'h80, 27'h401, 1'b0, 3,
                 32'h80000, pte_of(20'h81, 8'h01), 32'h81010, pte_of(20'h82, 8'h01),
                 32'h82008, pte_of(20'h83, 8'h01), 1'b1, 2'd2, 64'h0, 3, 7);
`ifdef PTW_AD_CHECK_EN
    vecs[5] = mk("store_dirty_clear", 20'h80, 27'h401, 1'b1, 3,
                 32'h80000, pte_of(20'h81, 8'h01), 32'h81010, pte_of(20'h82, 8'h01),
                 32'h82008, pte_of(20'h12345, 8'h4F), 1'b1, 2'd2, 64'h0, 3, 7);
`else
    vecs[5] = mk("store_dirty_clear", 20'h80, 27'h401, 1'b1, 3,
                 32'h80000, pte_of(20'h81, 8'h01), 32'h81010, pte_of(20'h82, 8'h01),
                 32'h82008, pte_of(20'h12345, 8'h4F), 1'b0, 2'd2, 64'h48D144F, 3, 7);
`endif
    vecs[6] = mk("mega_ok", 20'h80, 27'h401, 1'b0, 2,
                 32'h80000, pte_of(20'h81, 8'h01), 32'h81010, pte_of(20'h12200, 8'hCF),
                 32'h0, 64'h0, 1'b0, 2'd1, 64'h48800CF, 2, 5);
    vecs[7] = mk("mega_misaligned", 20'h80, 27'h401, 1'b0, 2,
                 32'h80000, pte_of(20'h81, 8'h01), 32'h81010, pte_of(20'h12201, 8'hCF),
                 32'h0, 64'h0, 1'b1, 2'd1, 64'h0, 2, 5);
    vecs[8] = mk("write_no_read", 20'h80, 27'h401, 1'b0, 1,
                 32'h80000, pte_of(20'h81, 8'h05), 32'h0, 64'h0, 32'h0, 64'h0,
                 1'b1, 2'd0, 64'h0, 1, 3);
    vecs[9] = mk("other_vpn", 20'h100, 27'hC0A07, 1'b0, 3,
                 32'h100018, pte_of(20'h200, 8'h01), 32'h200028, pte_of(20'h300, 8'h01),
                 32'h300038, pte_of(20'hABCDE, 8'hCB), 1'b0, 2'd2, 64'h2AF378CB, 3, 7);

    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("reset_ready", tlb_req_ready_o, 1);
    checkOutput("reset_resp_valid", ptw_resp_valid_o, 0);
    checkOutput("reset_resp_error", ptw_resp_error_o, 0);
    checkOutput("reset_resp_pte", ptw_resp_pte_o, 0);
    checkOutput("reset_resp_level", ptw_resp_level_o, 0);
    checkOutput("reset_invalidate", ptw_invalidate_o, 0);
    checkOutput("reset_mem_valid", mem_req_valid_o, 0);
    checkOutput("reset_mem_addr", mem_req_addr_o, 0);

    for (int i = 0; i < 10; i++) begin
      load_vec(vecs[i]);
      r0 = read_total;
      applyStimulus(vecs[i].satp, vecs[i].vpn, vecs[i].store, -1,
                    found, lat, err, lvl, pte, inval_t, inval_n, pulse_ok);
      checkOutput({vecs[i].name, "_found"}, found, 1);
      checkOutput({vecs[i].name, "_error"}, err, vecs[i].exp_err);
      checkOutput({vecs[i].name, "_level"}, lvl, vecs[i].exp_lvl);
      checkOutput({vecs[i].name, "_pte"}, pte, vecs[i].exp_pte);
      checkOutput({vecs[i].name, "_reads"}, read_total - r0, vecs[i].exp_reads);
      checkOutput({vecs[i].name, "_latency"}, lat, vecs[i].exp_lat);
      checkOutput({vecs[i].name, "_one_cycle_pulse"}, pulse_ok, 1);
    end

    // Memory holds off the first request for five cycles.
    load_vec(vecs[0]);
    r0 = read_total; s0 = stalls_given; v0 = stab_viol;
    stall_budget = stall_budget + 5;
    applyStimulus(20'h80, 27'h401, 1'b0, -1, found, lat, err, lvl, pte, inval_t, inval_n, pulse_ok);
    checkOutput("bp_stalls", stalls_given - s0, 5);
    checkOutput("bp_stable", stab_viol - v0, 0);
    checkOutput("bp_reads", read_total - r0, 3);
    checkOutput("bp_pte", pte, 64'h48D14CF);
    checkOutput("bp_latency", lat, 12);

    // sfence during the root read's wait: data discarded, walk restarts from root.
    load_vec(vecs[0]);
    resp_delay = 2;
    r0 = read_total; l0 = addr_log.size();
    applyStimulus(20'h80, 27'h401, 1'b0, 2, found, lat, err, lvl, pte, inval_t, inval_n, pulse_ok);
    checkOutput("sf_invalidate_cycle", inval_t, 3);
    checkOutput("sf_invalidate_count", inval_n, 1);
    checkOutput("sf_reads", read_total - r0, 4);
    checkOutput("sf_reread_root", (addr_log.size() > l0 + 1) ? addr_log[l0 + 1] : 32'hFFFF_FFFF, 32'h80000);
    checkOutput("sf_error", err, 0);
    checkOutput("sf_level", lvl, 2);
    checkOutput("sf_pte", pte, 64'h48D14CF);
    checkOutput("sf_latency", lat, 17);
    resp_delay = 0;

    // sfence together with the request in IDLE: accepted, no restart.
    r0 = read_total;
    applyStimulus(20'h80, 27'h401, 1'b0, 0, found, lat, err, lvl, pte, inval_t, inval_n, pulse_ok);
    checkOutput("sfidle_invalidate_cycle", inval_t, 1);
    checkOutput("sfidle_reads", read_total - r0, 3);
    checkOutput("sfidle_pte", pte, 64'h48D14CF);
    checkOutput("sfidle_latency", lat, 7);

    // Reset in the middle of a walk; the late memory response must be ignored.
    resp_delay = 3;
    @(negedge clk_i);
    satp_ppn_i = 20'h80; tlb_req_vpn_i = 27'h401; tlb_req_store_i = 1'b0; tlb_req_valid_i = 1'b1;
    @(negedge clk_i);
    tlb_req_valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    checkOutput("rst_mid_ready", tlb_req_ready_o, 1);
    checkOutput("rst_mid_mem_valid", mem_req_valid_o, 0);
    checkOutput("rst_mid_resp_valid", ptw_resp_valid_o, 0);
    seen_resp = 0; seen_req = 0;
    repeat (6) begin
      @(negedge clk_i);
      if (ptw_resp_valid_o) seen_resp++;
      if (mem_req_valid_o) seen_req++;
    end
    checkOutput("rst_late_resp_ignored", seen_resp, 0);
    checkOutput("rst_no_new_req", seen_req, 0);
    resp_delay = 0;
    applyStimulus(20'h80, 27'h401, 1'b0, -1, found, lat, err, lvl, pte, inval_t, inval_n, pulse_ok);
    checkOutput("rst_after_pte", pte, 64'h48D14CF);
    checkOutput("rst_after_latency", lat, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
